ch0re_execute: RTL and testbench
================================

# ch0re_execute

Execute stage of the ch0re pipeline and the master side of the ALU interface. It accepts one decoded instruction per cycle from decode and selects the ALU operands. It resolves branches and jumps from the ALU flags and registers the result into the EX/MEM pipeline register, using a valid/ready handshake on both sides. Taken control transfers produce a one-cycle redirect to fetch and squash the wrong-path instruction that follows.

## Interface
- No parameters. Datapath is fixed at 64 bits; register index is 5 bits.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  decode holds a valid instruction.
- o_ready  out  1  stage accepts this cycle; equals !o_valid || i_ready.
- i_pc  in  64  instruction address.
- i_alu_op  in  alu_op_e  operation.
- i_i64  in  data_type_e  word-op select; when asserted, the ALU sign-extends the result from bit 31.
- i_rs1_data, i_rs2_data  in  64  source operands.
- i_imm  in  64  sign-extended immediate.
- i_use_imm  in  1  s2 = i_imm instead of i_rs2_data.
- i_use_pc  in  1  s1 = i_pc instead of i_rs1_data (AUIPC, JAL).
- i_is_branch, i_is_jump  in  1  conditional branch / unconditional jump (JAL or JALR).
- i_rd  in  5  destination register; i_wb_en  in  1  destination write enable.
- i_flush  in  1  squash request from a later stage.
- alu  ch0re_alu_intf  master  drives i_op, i_i64, i_s1, i_s2; reads o_res, o_flag_zero, o_flag_less.
- o_valid  out  1  EX/MEM register holds a valid instruction; i_ready  in  1  MEM accepts.
- o_res  out  64; o_rd  out  5; o_wb_en  out  1  registered result to MEM.
- o_redirect  out  1; o_redirect_pc  out  64  fetch redirect.

## Operation
- Accept condition: i_valid && o_ready && !i_flush && !o_redirect.
- While o_redirect is high, an incoming instruction is wrong-path. It is consumed (o_ready honoured) and dropped: o_valid is not set.
- ALU drive, all cases:
  - s1 = i_use_pc ? i_pc : i_rs1_data.
  - s2 = i_use_imm ? i_imm : i_rs2_data.
  - op = i_alu_op.
- ALU drive, branch: op is forced to the i_alu_op comparison, s1/s2 are the rs1/rs2 data, and i_i64 is forced to the 64-bit encoding.
- ALU drive, jump: op is forced to ALU_ADD and i_i64 to the 64-bit encoding.
- Branch decision:
  - ALU_EQ: taken = o_flag_zero.
  - ALU_NE: taken = !o_flag_zero.
  - ALU_LT/ALU_LTU: taken = o_flag_less.
  - ALU_GE/ALU_GEU: taken = !o_flag_less.
  - Target = i_pc + i_imm, using a dedicated adder in the stage.
- Jumps: always taken.
  - Target = alu.o_res & ~64'h1.
  - Result = i_pc + 4, using a dedicated adder.
- Writeback fields:
  - Branches register o_wb_en = 0.
  - Jumps and ALU ops register o_wb_en = i_wb_en.
  - o_res = ALU result, or the link address for jumps.
- State is the EX/MEM register (o_valid, o_res, o_rd, o_wb_en) plus the redirect register (o_redirect, o_redirect_pc).
- Hold: when o_valid && !i_ready, all outputs stay stable and o_ready = 0.

## Timing
- Reset: o_valid = 0, o_res = 0, o_rd = 0, o_wb_en = 0, o_redirect = 0, o_redirect_pc = 0. Reset applies immediately, independent of i_clk.
- Latency: accept in cycle N gives o_valid = 1 in cycle N+1. Throughput is one instruction per cycle while i_ready = 1.
- Redirect timing: accepting a taken branch or jump in cycle N gives o_redirect = 1 for exactly cycle N+1, alongside that instruction's o_valid. o_redirect_pc holds its value until the next redirect.
- Redirect is a single pulse even if MEM stalls the instruction.
- Dequeue and accept in the same cycle are allowed (o_valid && i_ready && i_valid); the register reloads.
- i_flush in cycle N:
  - Next cycle: o_valid = 0, o_redirect = 0.
  - No accept occurs in cycle N.
  - i_flush has priority over hold, accept and redirect.
- Simultaneous o_redirect and i_flush: flush wins, and the redirect pulse is cleared at the next edge.
- Reset mid-stall drops the held instruction; no output glitches to valid.

## Test plan
- ALU ops:
  - ADD: rs1 = 5, imm = 7, use_imm, rd = 3 -> next cycle o_valid = 1, o_res = 12, o_rd = 3, o_wb_en = 1, o_redirect = 0.
  - ADDW: rs1 = 0x7FFFFFFF, imm = 1, word-op -> o_res = 0xFFFFFFFF80000000.
- Branch taken: BEQ with pc = 0x1000, rs1 = rs2 = 0x55, imm = 0x20 -> o_redirect = 1 for one cycle, o_redirect_pc = 0x1020, o_wb_en = 0. An instruction presented on the following cycle is consumed without producing o_valid.
- Signed/unsigned compare: BLT with rs1 = -1, rs2 = 1 -> taken. BLTU with the same operands -> not taken, o_redirect = 0.
- JALR: pc = 0x2000, rs1 = 0x3001, imm = 4, rd = 1 -> o_res = 0x2004, o_redirect_pc = 0x3004, o_wb_en = 1.
- Backpressure: hold i_ready = 0 for 3 cycles with o_valid = 1 -> o_ready = 0 and all outputs stable. After release, back-to-back instructions issue at one per cycle.
- Flush and reset:
  - i_flush alongside a pending taken branch -> o_valid = 0, o_redirect = 0.
  - Asserting i_rst mid-stall -> all outputs 0 immediately; normal operation resumes after deassertion.

Source files
------------

// File: rtl/ch0re_execute_if.sv
// rtl/ch0re_execute_if.sv - shared ALU types and the execute/ALU interface
package ch0re_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU
  } alu_op_e;

  // DT_WORD asks the ALU to sign-extend its result from bit 31
  typedef enum logic {
    DT_DWORD = 1'b0,
    DT_WORD  = 1'b1
  } data_type_e;

endpackage

// o_flag_zero reports i_s1 == i_s2; o_flag_less reports i_s1 < i_s2,
// unsigned for the *U comparisons and signed otherwise.
interface ch0re_alu_intf;
  import ch0re_pkg::*;

  alu_op_e     i_op;
  data_type_e  i_i64;
  logic [63:0] i_s1;
  logic [63:0] i_s2;
  logic [63:0] o_res;
  logic        o_flag_zero;
  logic        o_flag_less;

  modport master (
    output i_op, i_i64, i_s1, i_s2,
    input  o_res, o_flag_zero, o_flag_less
  );

  modport slave (
    input  i_op, i_i64, i_s1, i_s2,
    output o_res, o_flag_zero, o_flag_less
  );
endinterface

// File: rtl/ch0re_execute.sv
// rtl/ch0re_execute.sv - ch0re execute stage: ALU operand select, branch resolve, EX/MEM register
module ch0re_execute
  import ch0re_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_pc,
  input  alu_op_e     i_alu_op,
  input  data_type_e  i_i64,
  input  logic [63:0] i_rs1_data,
  input  logic [63:0] i_rs2_data,
  input  logic [63:0] i_imm,
  input  logic        i_use_imm,
  input  logic        i_use_pc,
  input  logic        i_is_branch,
  input  logic        i_is_jump,
  input  logic [4:0]  i_rd,
  input  logic        i_wb_en,
  input  logic        i_flush,
  ch0re_alu_intf.master alu,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_res,
  output logic [4:0]  o_rd,
  output logic        o_wb_en,
  output logic        o_redirect,
  output logic [63:0] o_redirect_pc
);

  logic        accept;
  logic        dequeue;
  logic        cond;
  logic        taken;
  logic [63:0] branch_target;
  logic [63:0] link_addr;
  logic [63:0] target;
  logic [63:0] result;
  logic        wb_next;

  // Stage is free when empty or when MEM drains the current entry this cycle
  assign o_ready = !o_valid || i_ready;

  // The instruction right behind a taken transfer is wrong-path and is dropped
  assign accept  = i_valid && o_ready && !i_flush && !o_redirect;
  assign dequeue = o_valid && i_ready;

  // Dedicated adders keep the branch target and link address off the ALU
  assign branch_target = i_pc + i_imm;
  assign link_addr     = i_pc + 64'd4;

  // ALU operand and opcode selection; branches compare rs1/rs2, jumps add
  always_comb begin
    alu.i_op  = i_alu_op;
    alu.i_i64 = i_i64;
    alu.i_s1  = i_use_pc ? i_pc : i_rs1_data;
    alu.i_s2  = i_use_imm ? i_imm : i_rs2_data;
    if (i_is_branch) begin
      alu.i_i64 = DT_DWORD;
      alu.i_s1  = i_rs1_data;
      alu.i_s2  = i_rs2_data;
    end else if (i_is_jump) begin
      alu.i_op  = ALU_ADD;
      alu.i_i64 = DT_DWORD;
    end
  end

  // Resolve control transfer, target, result and writeback enable
  always_comb begin
    cond = 1'b0;
    case (i_alu_op)
      ALU_EQ:          cond = alu.o_flag_zero;
      ALU_NE:          cond = !alu.o_flag_zero;
      ALU_LT, ALU_LTU: cond = alu.o_flag_less;
      ALU_GE, ALU_GEU: cond = !alu.o_flag_less;
      default:         cond = 1'b0;
    endcase
    taken   = i_is_jump || (i_is_branch && cond);
    target  = i_is_jump ? (alu.o_res & ~64'h1) : branch_target;
    result  = i_is_jump ? link_addr : alu.o_res;
    wb_next = i_is_branch ? 1'b0 : i_wb_en;
  end

  // EX/MEM register and one-cycle redirect pulse; flush beats hold, accept and redirect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_res         <= 64'd0;
      o_rd          <= 5'd0;
      o_wb_en       <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= 64'd0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      o_redirect <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_res      <= result;
      o_rd       <= i_rd;
      o_wb_en    <= wb_next;
      o_redirect <= taken;
      if (taken) begin
        o_redirect_pc <= target;
      end
    end else begin
      if (dequeue) begin
        o_valid <= 1'b0;
      end
      o_redirect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ch0re_execute.sv
// tb/tb_ch0re_execute.sv - self-checking bench for ch0re_execute
module tb_ch0re_execute;
  import ch0re_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_pc;
  alu_op_e     i_alu_op;
  data_type_e  i_i64;
  logic [63:0] i_rs1_data;
  logic [63:0] i_rs2_data;
  logic [63:0] i_imm;
  logic        i_use_imm;
  logic        i_use_pc;
  logic        i_is_branch;
  logic        i_is_jump;
  logic [4:0]  i_rd;
  logic        i_wb_en;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_res;
  logic [4:0]  o_rd;
  logic        o_wb_en;
  logic        o_redirect;
  logic [63:0] o_redirect_pc;

  int total;
  int passed;

  alu_op_e alu_list [10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                             ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};
  alu_op_e br_list [6]   = '{ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU};

  ch0re_alu_intf alu_bus ();

  ch0re_execute dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_pc          (i_pc),
    .i_alu_op      (i_alu_op),
    .i_i64         (i_i64),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .i_imm         (i_imm),
    .i_use_imm     (i_use_imm),
    .i_use_pc      (i_use_pc),
    .i_is_branch   (i_is_branch),
    .i_is_jump     (i_is_jump),
    .i_rd          (i_rd),
    .i_wb_en       (i_wb_en),
    .i_flush       (i_flush),
    .alu           (alu_bus),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_res         (o_res),
    .o_rd          (o_rd),
    .o_wb_en       (o_wb_en),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Arithmetic of an RV64 ALU, optionally as a word op
  function automatic logic [63:0] calc(input alu_op_e op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[5:0];
      ALU_SRL:  r = a >> b[5:0];
      ALU_SRA:  r = $signed(a) >>> b[5:0];
      ALU_SLT, ALU_LT:   r = {63'd0, $signed(a) < $signed(b)};
      ALU_SLTU, ALU_LTU: r = {63'd0, a < b};
      ALU_GE:   r = {63'd0, $signed(a) >= $signed(b)};
      ALU_GEU:  r = {63'd0, a >= b};
      ALU_EQ:   r = {63'd0, a == b};
      ALU_NE:   r = {63'd0, a != b};
      default:  r = 64'd0;
    endcase
    if (word) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Behavioural ALU slave on the interface
  always_comb begin
    alu_bus.o_res       = calc(alu_bus.i_op, alu_bus.i_i64 == DT_WORD, alu_bus.i_s1, alu_bus.i_s2);
    alu_bus.o_flag_zero = (alu_bus.i_s1 == alu_bus.i_s2);
    if (alu_bus.i_op == ALU_LTU || alu_bus.i_op == ALU_GEU || alu_bus.i_op == ALU_SLTU)
      alu_bus.o_flag_less = (alu_bus.i_s1 < alu_bus.i_s2);
    else
      alu_bus.o_flag_less = ($signed(alu_bus.i_s1) < $signed(alu_bus.i_s2));
  end

  // Reference outcome of the instruction currently presented by the bench
  task automatic ref_exec(output logic [63:0] res, output logic res_chk, output logic wb,
                          output logic taken, output logic [63:0] tgt);
    logic [63:0] s1;
    logic [63:0] s2;
    s1 = i_use_pc ? i_pc : i_rs1_data;
    s2 = i_use_imm ? i_imm : i_rs2_data;
    res_chk = 1'b1;
    if (i_is_branch) begin
      case (i_alu_op)
        ALU_EQ:  taken = (i_rs1_data == i_rs2_data);
        ALU_NE:  taken = (i_rs1_data != i_rs2_data);
        ALU_LT:  taken = ($signed(i_rs1_data) < $signed(i_rs2_data));
        ALU_LTU: taken = (i_rs1_data < i_rs2_data);
        ALU_GE:  taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
        default: taken = (i_rs1_data >= i_rs2_data);
      endcase
      tgt = i_pc + i_imm;
      res = 64'd0;
      res_chk = 1'b0;
      wb = 1'b0;
    end else if (i_is_jump) begin
      taken = 1'b1;
      tgt = (s1 + s2) & ~64'h1;
      res = i_pc + 64'd4;
      wb = i_wb_en;
    end else begin
      taken = 1'b0;
      tgt = 64'd0;
      res = calc(i_alu_op, i_i64 == DT_WORD, s1, s2);
      wb = i_wb_en;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_flush = 1'b0; i_pc = 64'd0; i_alu_op = ALU_ADD; i_i64 = DT_DWORD;
    i_rs1_data = 64'd0; i_rs2_data = 64'd0; i_imm = 64'd0; i_use_imm = 1'b0; i_use_pc = 1'b0;
    i_is_branch = 1'b0; i_is_jump = 1'b0; i_rd = 5'd0; i_wb_en = 1'b0;
  endtask

  task automatic set_instr(input logic [63:0] pc, input alu_op_e op, input logic word,
                           input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                           input logic uimm, input logic upc, input logic br, input logic jmp,
                           input logic [4:0] rd, input logic wb);
    i_valid = 1'b1; i_pc = pc; i_alu_op = op; i_i64 = word ? DT_WORD : DT_DWORD;
    i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm; i_use_imm = uimm; i_use_pc = upc;
    i_is_branch = br; i_is_jump = jmp; i_rd = rd; i_wb_en = wb;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ready = 1'b1; idle();
    #1;
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", o_valid); else passed++;
    total++; if (o_res !== 64'd0) $display("FAIL reset_res got %h exp 0", o_res); else passed++;
    total++; if (o_rd !== 5'd0) $display("FAIL reset_rd got %0d exp 0", o_rd); else passed++;
    total++; if (o_wb_en !== 1'b0) $display("FAIL reset_wb got %0b exp 0", o_wb_en); else passed++;
    total++; if (o_redirect !== 1'b0) $display("FAIL reset_redirect got %0b exp 0", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 64'd0) $display("FAIL reset_rpc got %h exp 0", o_redirect_pc); else passed++;
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_ops();
    i_ready = 1'b1;
    set_instr(64'h100, ALU_ADD, 1'b0, 64'd5, 64'd0, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    tick(); idle();
    total++; if (o_valid !== 1'b1) $display("FAIL add_valid got %0b exp 1", o_valid); else passed++;
    total++; if (o_res !== 64'd12) $display("FAIL add_res got %h exp %h", o_res, 64'd12); else passed++;
    total++; if (o_rd !== 5'd3) $display("FAIL add_rd got %0d exp 3", o_rd); else passed++;
    total++; if (o_wb_en !== 1'b1) $display("FAIL add_wb got %0b exp 1", o_wb_en); else passed++;
    total++; if (o_redirect !== 1'b0) $display("FAIL add_redirect got %0b exp 0", o_redirect); else passed++;
    set_instr(64'h104, ALU_ADD, 1'b1, 64'h7FFF_FFFF, 64'd0, 64'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    tick(); idle();
    total++; if (o_res !== 64'hFFFF_FFFF_8000_0000) $display("FAIL addw_res got %h exp ffffffff80000000", o_res); else passed++;
    tick();
    total++; if (o_valid !== 1'b0) $display("FAIL drain_valid got %0b exp 0", o_valid); else passed++;
  endtask

  task automatic test_branch();
    i_ready = 1'b1;
    set_instr(64'h1000, ALU_EQ, 1'b0, 64'h55, 64'h55, 64'h20, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1);
    tick();
    total++; if (o_valid !== 1'b1) $display("FAIL beq_valid got %0b exp 1", o_valid); else passed++;
    total++; if (o_redirect !== 1'b1) $display("FAIL beq_redirect got %0b exp 1", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 64'h1020) $display("FAIL beq_rpc got %h exp 1020", o_redirect_pc); else passed++;
    total++; if (o_wb_en !== 1'b0) $display("FAIL beq_wb got %0b exp 0", o_wb_en); else passed++;
    set_instr(64'h1004, ALU_ADD, 1'b0, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
    #1;
    total++; if (o_ready !== 1'b1) $display("FAIL wrongpath_ready got %0b exp 1", o_ready); else passed++;
    tick(); idle();
    total++; if (o_valid !== 1'b0) $display("FAIL wrongpath_valid got %0b exp 0", o_valid); else passed++;
    total++; if (o_redirect !== 1'b0) $display("FAIL beq_pulse got %0b exp 0", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 64'h1020) $display("FAIL rpc_hold got %h exp 1020", o_redirect_pc); else passed++;
  endtask

  task automatic test_compare();
    i_ready = 1'b1;
    set_instr(64'h300, ALU_LT, 1'b0, '1, 64'd1, 64'h40, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    total++; if (o_redirect !== 1'b1) $display("FAIL blt_taken got %0b exp 1", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 64'h340) $display("FAIL blt_rpc got %h exp 340", o_redirect_pc); else passed++;
    tick();
    set_instr(64'h300, ALU_LTU, 1'b0, '1, 64'd1, 64'h80, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    total++; if (o_valid !== 1'b1) $display("FAIL bltu_valid got %0b exp 1", o_valid); else passed++;
    total++; if (o_redirect !== 1'b0) $display("FAIL bltu_taken got %0b exp 0", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 64'h340) $display("FAIL bltu_rpc got %h exp 340", o_redirect_pc); else passed++;
    tick();
  endtask

  task automatic test_jalr();
    i_ready = 1'b1;
    set_instr(64'h2000, ALU_SUB, 1'b0, 64'h3001, 64'd0, 64'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1);
    tick(); idle();
    total++; if (o_res !== 64'h2004) $display("FAIL jalr_res got %h exp 2004", o_res); else passed++;
    total++; if (o_redirect_pc !== 64'h3004) $display("FAIL jalr_rpc got %h exp 3004", o_redirect_pc); else passed++;
    total++; if (o_wb_en !== 1'b1) $display("FAIL jalr_wb got %0b exp 1", o_wb_en); else passed++;
    total++; if (o_rd !== 5'd1) $display("FAIL jalr_rd got %0d exp 1", o_rd); else passed++;
    total++; if (o_redirect !== 1'b1) $display("FAIL jalr_redirect got %0b exp 1", o_redirect); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    set_instr(64'h400, ALU_ADD, 1'b0, 64'd10, 64'd0, 64'd20, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    tick();
    set_instr(64'h404, ALU_ADD, 1'b0, 64'd100, 64'd0, 64'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (o_ready !== 1'b0) $display("FAIL hold_ready c%0d got %0b exp 0", k, o_ready); else passed++;
      total++; if (o_valid !== 1'b1) $display("FAIL hold_valid c%0d got %0b exp 1", k, o_valid); else passed++;
      total++; if (o_res !== 64'd30 || o_rd !== 5'd4) $display("FAIL hold_data c%0d got %h/%0d exp 1e/4", k, o_res, o_rd); else passed++;
      tick();
    end
    i_ready = 1'b1;
    tick();
    total++; if (o_valid !== 1'b1 || o_res !== 64'd101) $display("FAIL b2b_first got %0b/%h exp 1/65", o_valid, o_res); else passed++;
    set_instr(64'h408, ALU_ADD, 1'b0, 64'd200, 64'd0, 64'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
    tick(); idle();
    total++; if (o_valid !== 1'b1 || o_res !== 64'd202 || o_rd !== 5'd6) $display("FAIL b2b_second got %0b/%h/%0d exp 1/ca/6", o_valid, o_res, o_rd); else passed++;
    tick();
    total++; if (o_valid !== 1'b0) $display("FAIL b2b_drain got %0b exp 0", o_valid); else passed++;
  endtask

  task automatic test_flush();
    i_ready = 1'b1;
    set_instr(64'h4000, ALU_EQ, 1'b0, 64'd3, 64'd3, 64'h10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    i_flush = 1'b1;
    tick(); idle();
    total++; if (o_valid !== 1'b0 || o_redirect !== 1'b0) $display("FAIL flush_accept got %0b/%0b exp 0/0", o_valid, o_redirect); else passed++;
    total++; if (o_redirect_pc !== 64'h3004) $display("FAIL flush_rpc got %h exp 3004", o_redirect_pc); else passed++;
    set_instr(64'h5000, ALU_EQ, 1'b0, 64'd3, 64'd3, 64'h8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); idle();
    total++; if (o_redirect !== 1'b1) $display("FAIL flush_pre got %0b exp 1", o_redirect); else passed++;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    total++; if (o_valid !== 1'b0 || o_redirect !== 1'b0) $display("FAIL flush_redirect got %0b/%0b exp 0/0", o_valid, o_redirect); else passed++;
  endtask

  task automatic test_reset_midstall();
    i_ready = 1'b0;
    set_instr(64'h600, ALU_ADD, 1'b0, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick(); idle();
    total++; if (o_valid !== 1'b1) $display("FAIL stall_valid got %0b exp 1", o_valid); else passed++;
    #2 i_rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0 || o_wb_en !== 1'b0 || o_redirect !== 1'b0) $display("FAIL rst_ctl got %0b%0b%0b exp 000", o_valid, o_wb_en, o_redirect); else passed++;
    total++; if (o_res !== 64'd0 || o_rd !== 5'd0 || o_redirect_pc !== 64'd0) $display("FAIL rst_data got %h/%0d/%h exp 0", o_res, o_rd, o_redirect_pc); else passed++;
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    i_ready = 1'b1;
    set_instr(64'h700, ALU_ADD, 1'b0, 64'd40, 64'd0, 64'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
    tick(); idle();
    total++; if (o_valid !== 1'b1 || o_res !== 64'd42 || o_rd !== 5'd9) $display("FAIL resume got %0b/%h/%0d exp 1/2a/9", o_valid, o_res, o_rd); else passed++;
    tick();
  endtask

  task automatic test_random();
    logic        e_valid, e_redir, e_wb, e_chk, rdy;
    logic [63:0] e_res, e_rpc;
    logic [4:0]  e_rd;
    logic [63:0] r_res, r_tgt;
    logic        r_chk, r_wb, r_taken;
    logic [11:0] imm12;
    int          kind;
    idle();
    i_rst = 1'b1; #1; i_rst = 1'b0;
    e_valid = 1'b0; e_redir = 1'b0; e_rpc = 64'd0; e_res = 64'd0; e_rd = 5'd0; e_wb = 1'b0; e_chk = 1'b0;
    tick();
    for (int c = 0; c < 400; c++) begin
      total++; if (o_valid !== e_valid) $display("FAIL rnd_valid c%0d got %0b exp %0b", c, o_valid, e_valid); else passed++;
      total++; if (o_redirect !== e_redir) $display("FAIL rnd_redirect c%0d got %0b exp %0b", c, o_redirect, e_redir); else passed++;
      total++; if (o_redirect_pc !== e_rpc) $display("FAIL rnd_rpc c%0d got %h exp %h", c, o_redirect_pc, e_rpc); else passed++;
      if (e_valid) begin
        total++; if (o_rd !== e_rd || o_wb_en !== e_wb) $display("FAIL rnd_rdwb c%0d got %0d/%0b exp %0d/%0b", c, o_rd, o_wb_en, e_rd, e_wb); else passed++;
        if (e_chk) begin
          total++; if (o_res !== e_res) $display("FAIL rnd_res c%0d got %h exp %h", c, o_res, e_res); else passed++;
        end
      end
      kind = int'($urandom_range(0, 2));
      imm12 = 12'($urandom);
      i_valid     = ($urandom_range(0, 3) != 0);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_flush     = ($urandom_range(0, 19) == 0);
      i_pc        = {$urandom(), $urandom()};
      i_rs1_data  = {$urandom(), $urandom()};
      i_rs2_data  = ($urandom_range(0, 3) == 0) ? i_rs1_data : {$urandom(), $urandom()};
      i_imm       = {{52{imm12[11]}}, imm12};
      i_use_imm   = ($urandom_range(0, 1) == 1);
      i_use_pc    = ($urandom_range(0, 1) == 1);
      i_i64       = ($urandom_range(0, 1) == 1) ? DT_WORD : DT_DWORD;
      i_rd        = 5'($urandom);
      i_wb_en     = ($urandom_range(0, 1) == 1);
      i_is_branch = (kind == 1);
      i_is_jump   = (kind == 2);
      i_alu_op    = (kind == 1) ? br_list[$urandom_range(0, 5)] : alu_list[$urandom_range(0, 9)];
      #1;
      rdy = !e_valid || i_ready;
      total++; if (o_ready !== rdy) $display("FAIL rnd_ready c%0d got %0b exp %0b", c, o_ready, rdy); else passed++;
      if (i_flush) begin
        e_valid = 1'b0; e_redir = 1'b0;
      end else if (i_valid && rdy && !e_redir) begin
        ref_exec(r_res, r_chk, r_wb, r_taken, r_tgt);
        e_valid = 1'b1; e_res = r_res; e_chk = r_chk; e_wb = r_wb; e_rd = i_rd; e_redir = r_taken;
        if (r_taken) e_rpc = r_tgt;
      end else begin
        if (e_valid && i_ready) e_valid = 1'b0;
        e_redir = 1'b0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_alu_ops();
    test_branch();
    test_compare();
    test_jalr();
    test_backpressure();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
